// File: rtl/config_source_arbiter.sv
// config_source_arbiter: gives one of UART, BitBang or Self ownership of the ConfigFSM write port for a whole session.
// Ports:
//   CLK, Reset_n                      clock, asynchronous active-low reset
//   UART_Active/BitBang_Active/Self_Active                  session request levels
//   UART_WriteData/BitBang_WriteData/SelfWriteData          32-bit source write words
//   UART_WriteStrobe/BitBang_WriteStrobe/SelfWriteStrobe    single-cycle source strobes
//   DropClear                         synchronous clear of DropCount
//   ConfigWriteData/ConfigWriteStrobe registered write to ConfigFSM
//   SessionReset                      one-cycle ConfigFSM reset on every ownership switch
//   Owner                             00 none, 01 UART, 10 BitBang, 11 Self
//   Busy                              high outside IDLE
//   DropCount                         saturating count of cycles with a discarded strobe
module config_source_arbiter #(
    parameter int GAP_CYCLES  = 2,
    parameter int HOLD_CYCLES = 4,
    parameter bit PREEMPT     = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        UART_Active,
    input  logic        BitBang_Active,
    input  logic        Self_Active,
    input  logic [31:0] UART_WriteData,
    input  logic [31:0] BitBang_WriteData,
    input  logic [31:0] SelfWriteData,
    input  logic        UART_WriteStrobe,
    input  logic        BitBang_WriteStrobe,
    input  logic        SelfWriteStrobe,
    input  logic        DropClear,
    output logic [31:0] ConfigWriteData,
    output logic        ConfigWriteStrobe,
    output logic        SessionReset,
    output logic [1:0]  Owner,
    output logic        Busy,
    output logic [7:0]  DropCount
);
    typedef enum logic [1:0] {IDLE, SWITCH, OWN, RELEASE} stateType;
    // One counter serves both the guard gap and the release hold; the two never overlap.
    localparam int CntW = $clog2((GAP_CYCLES > HOLD_CYCLES ? GAP_CYCLES : HOLD_CYCLES) + 1);
    stateType state, stateNext;
    logic [1:0] ownerNext, best;
    logic [CntW-1:0] cnt, cntNext;
    logic [3:0] activeVec, strobeVec, fwdMask;
    logic [31:0] ownerData;
    logic ownerActive, forward, drop, preemptNow, switchNow;
    // Bit 0 stands for "no owner" so the owner code indexes the vectors directly.
    assign activeVec = {Self_Active, BitBang_Active, UART_Active, 1'b0};
    assign strobeVec = {SelfWriteStrobe, BitBang_WriteStrobe, UART_WriteStrobe, 1'b0};
    assign best = UART_Active ? 2'd1 : BitBang_Active ? 2'd2 : Self_Active ? 2'd3 : 2'd0;
    assign ownerActive = activeVec[Owner];
    assign ownerData = Owner == 2'd1 ? UART_WriteData : Owner == 2'd2 ? BitBang_WriteData : SelfWriteData;
    assign forward = (state == OWN || state == RELEASE) && strobeVec[Owner];
    assign fwdMask = forward ? (4'b0001 << Owner) : 4'b0000;
    assign drop = |(strobeVec & ~fwdMask);
    // Lower code means higher priority; Owner is 00 only in IDLE where this is unused.
    assign preemptNow = PREEMPT && best != 2'd0 && best < Owner;
    assign Busy = state != IDLE;
    always_comb begin
        stateNext = state;
        ownerNext = Owner;
        cntNext = cnt;
        switchNow = 1'b0;
        case (state)
            IDLE: switchNow = best != 2'd0;
            SWITCH: begin
                if (preemptNow) switchNow = 1'b1;
                else if (cnt == CntW'(1)) stateNext = OWN;
                else cntNext = cnt - CntW'(1);
            end
            OWN: begin
                if (preemptNow) switchNow = 1'b1;
                else if (!ownerActive) begin
                    stateNext = RELEASE;
                    cntNext = CntW'(HOLD_CYCLES);
                end
            end
            RELEASE: begin
                if (preemptNow) switchNow = 1'b1;
                else if (ownerActive) stateNext = OWN;
                else if (cnt == CntW'(1)) begin
                    if (best != 2'd0) switchNow = 1'b1;
                    else begin
                        stateNext = IDLE;
                        ownerNext = 2'd0;
                    end
                end else cntNext = cnt - CntW'(1);
            end
            default: ;
        endcase
        if (switchNow) begin
            stateNext = SWITCH;
            ownerNext = best;
            cntNext = CntW'(GAP_CYCLES);
        end
    end
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            Owner <= 2'd0;
            cnt <= '0;
            SessionReset <= 1'b0;
            ConfigWriteStrobe <= 1'b0;
            ConfigWriteData <= '0;
            DropCount <= '0;
        end else begin
            state <= stateNext;
            Owner <= ownerNext;
            cnt <= cntNext;
            SessionReset <= switchNow;
            ConfigWriteStrobe <= forward;
            if (forward) ConfigWriteData <= ownerData;
            if (DropClear) DropCount <= '0;
            else if (drop && DropCount != 8'hFF) DropCount <= DropCount + 8'd1;
        end
    end
endmodule

// File: doc/config_source_arbiter.md
# config_source_arbiter

Arbitrates the fabric configuration write port between three sources (UART loader, bit-bang port, CPU self-write) and hands exactly one of them ownership of the ConfigFSM input for a whole session. Fixed priority applies: UART > BitBang > Self. Each ownership change is framed by a ConfigFSM session reset and a guard gap. Non-owner strobes are discarded and counted. It sits between the source ports and ConfigFSM inside the configuration block and replaces the combinational priority mux.

## Interface

Parameters:
- GAP_CYCLES, 2: guard cycles (≥1) after an ownership switch before owner strobes are forwarded.
- HOLD_CYCLES, 4: cycles (≥1) ownership is retained after the owner's Active falls.
- PREEMPT, 1: 1 = a higher-priority Active seizes the port from a lower owner; 0 = it waits for release.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- UART_Active, BitBang_Active, Self_Active  in  1 each  source session-request levels.
- UART_WriteData, BitBang_WriteData, SelfWriteData  in  32 each  source write words.
- UART_WriteStrobe, BitBang_WriteStrobe, SelfWriteStrobe  in  1 each  single-cycle write strobes.
- DropClear  in  1  synchronous clear of DropCount.
- ConfigWriteData  out  32  registered data to ConfigFSM.
- ConfigWriteStrobe  out  1  registered strobe to ConfigFSM.
- SessionReset  out  1  one-cycle ConfigFSM reset pulse on each ownership switch.
- Owner  out  2  00 none, 01 UART, 10 BitBang, 11 Self.
- Busy  out  1  high in every state except IDLE.
- DropCount  out  8  saturating count of cycles with a discarded strobe.

## Operation

- States: IDLE, SWITCH, OWN, RELEASE. Owner register tracks the current owner.
- "Best" is the highest-priority source whose Active is high.
- IDLE:
  - Owner=00.
  - If any Active is high, load Owner=best, assert SessionReset on the next cycle, go to SWITCH, and load the gap counter with GAP_CYCLES.
- SWITCH:
  - Decrement the gap counter each cycle. When it expires, go to OWN.
  - All strobes are dropped, including the owner's.
  - A higher-priority Active arriving during SWITCH with PREEMPT=1 restarts SWITCH with the new owner and issues a new SessionReset.
- OWN:
  - Forward the owner's WriteData/WriteStrobe to the outputs.
  - If the owner's Active goes low, go to RELEASE and load the hold counter with HOLD_CYCLES.
  - If PREEMPT=1 and best is higher priority than Owner, go to SWITCH with Owner=best.
- RELEASE:
  - Owner strobes are still forwarded.
  - If the owner's Active goes high again, return to OWN. No SessionReset is issued.
  - If PREEMPT=1 and a higher-priority Active is present, go to SWITCH to it. With PREEMPT=0, a higher-priority request waits here for release.
  - When the hold counter expires: if any Active is high, go to SWITCH with best; otherwise go to IDLE.
- Drop rule: any cycle in which a non-forwarded strobe is high increments DropCount by 1, however many strobes are high. DropCount saturates at 255.
- DropClear has precedence: a clear and a drop in the same cycle leave DropCount=0.
- ConfigWriteData holds its last value when the strobe is low. It updates only on forwarded strobes.

## Timing

- Reset values: state IDLE, Owner=00, Busy=0, SessionReset=0, ConfigWriteStrobe=0, ConfigWriteData=0, DropCount=0.
- Reset_n assertion clears all of the above immediately (asynchronous). Any session in progress is abandoned with no trailing strobe.
- Forwarding latency: an owner strobe sampled at edge n gives ConfigWriteStrobe high for one cycle after edge n+1, with its data.
- Session start: an Active sampled at edge k in IDLE gives:
  - Owner, Busy and SessionReset valid after edge k+1, with SessionReset high for exactly one cycle;
  - SWITCH lasting GAP_CYCLES cycles;
  - owner strobes forwarded if sampled at edge k+1+GAP_CYCLES or later.
- Release: the owner's Active sampled low at edge r in OWN gives:
  - ownership kept through edge r+HOLD_CYCLES;
  - IDLE reached after edge r+1+HOLD_CYCLES if no source is active.
- Strobes are never merged or queued. A dropped strobe is lost.

## Test plan

- Basic session (GAP=2, HOLD=4):
  - Stimulus: UART_Active high at edge 10, UART strobe with 0xA5A5_0001 at edge 14.
  - Required: SessionReset high for 1 cycle after edge 11; Owner=01; ConfigWriteStrobe with 0xA5A5_0001 after edge 15.
- Guard drop:
  - Stimulus: BitBang session, owner strobe during SWITCH.
  - Required: no ConfigWriteStrobe; DropCount=1.
- Preemption (PREEMPT=1):
  - Stimulus: Self owns the port, then UART_Active rises.
  - Required: Owner goes 11 then 01; a second SessionReset; Self strobes after the switch are dropped and counted.
- No preemption (PREEMPT=0):
  - Stimulus: same as the preemption case.
  - Required: Self keeps ownership until its release plus 4 cycles, then UART gets SWITCH.
- Release bounce:
  - Stimulus: the owner's Active drops for 2 cycles, then returns.
  - Required: back to OWN; no SessionReset; trailing strobe in RELEASE is forwarded.
- Reset and counter:
  - Stimulus: 300 dropped strobes.
  - Required: DropCount=255. DropClear coincident with a drop gives 0. Reset_n low mid-OWN clears all outputs within the same cycle.
